sgdmac_mch_cfg: RTL and testbench
=================================

// Module: sgdmac_mch_cfg
// PURPOSE
//  APB slave register file for the multi-channel scatter-gather DMA engine.
//  Holds a descriptor start pointer per channel and issues one-cycle start pulses.
//  Tracks per-channel busy state from start to done, with sticky W1C done/error flags.
//  Drives one maskable interrupt. Sits between the APB fabric and the N_CH SG engines.
// PARAMETERS
//  N_CH     4            number of DMA channels, legal 1..16
//  VERSION  32'h0002_0000 value returned by the VERSION register
// PORTS
//  clk              in   1        clock
//  rst              in   1        asynchronous reset, active-high
//  psel_i           in   1        APB select
//  penable_i        in   1        APB enable (access phase)
//  paddr_i          in   12       APB byte address; bits[1:0] ignored
//  pwrite_i         in   1        1 = write
//  pwdata_i         in   32       write data
//  pready_o         out  1        constant 1: zero-wait slave
//  prdata_o         out  32       read data, valid in access phase
//  pslverr_o        out  1        error response, valid in access phase
//  start_pointer_o  out  N_CH*32  channel c pointer at [32c+31:32c]
//  start_o          out  N_CH     one-cycle start pulse per channel
//  busy_o           out  N_CH     channel busy flag
//  done_i           in   N_CH     engine done pulse per channel
//  irq_o            out  1        |(done_flag & irq_en), registered
// BEHAVIOUR
//  Reset (async, rst=1): all pointers 0, start_o 0, busy_o 0, all flags 0,
//   IRQ_EN 0, irq_o 0. pready_o is 1 at all times.
//  Access phase = psel_i & penable_i. Setup phase has no side effects.
//  prdata_o and pslverr_o are combinational in the access phase and 0 otherwise.
//  Register map:
//   0x000 VERSION RO
//   0x004 IRQ_EN RW [N_CH-1:0]
//   0x008 IRQ_STAT RO = done_flag & irq_en
//   0x100+0x10*c  PTR    RW 32b channel start pointer
//   0x104+0x10*c  CMD    WO bit0=start; reads return 0
//   0x108+0x10*c  STATUS RO bit0=busy
//   0x10C+0x10*c  FLAGS  W1C bit0=done, bit1=start_err
//  Error cases: set pslverr_o=1, return prdata 0, change no state.
//   - unmapped address, including channel index >= N_CH
//   - write to a RO register
//   - write to PTR while that channel is busy
//  Per-channel FSM IDLE<->BUSY:
//   - IDLE: CMD write with bit0=1 -> start_o[c]=1 the next cycle for exactly
//     1 cycle; busy set that same next cycle.
//   - BUSY: CMD start -> no pulse; start_err set; no pslverr.
//   - BUSY: done_i[c] -> IDLE next cycle; done flag set.
//   - done_i while IDLE is ignored.
//  CMD write with bit0=0 has no effect.
//  Flag W1C in the same cycle as a flag-set event: the set wins.
//  irq_o is updated one cycle after the flag or IRQ_EN change.
//  Reset asserted mid-transfer clears busy immediately; a later done_i is ignored.
//  All channels are independent; simultaneous done_i on several channels are all captured.
// TESTING
//  Reset -> read VERSION=0x0002_0000, STATUS0=0, irq_o=0, pready_o=1.
//  Write PTR1=0x8000_1000, CMD1=1 -> start_o=4'b0010 for 1 cycle;
//   start_pointer_o[63:32]=0x8000_1000; busy_o[1]=1.
//  Ch1 busy: CMD1=1 -> no pulse, FLAGS1=0x2; PTR1 write -> pslverr, value unchanged.
//  IRQ_EN=0x2, done_i[1] -> busy_o[1]=0, FLAGS1 bit0=1, irq_o=1; write FLAGS1=1 -> irq_o=0.
//  done_i[2] in the same cycle as a W1C of FLAGS2=1 -> FLAGS2 bit0 stays 1.
//  N_CH=4: read 0x140 and write 0x000 -> pslverr_o=1, no state change.

Source files
------------

// File: rtl/sgdmac_mch_cfg.sv
// sgdmac_mch_cfg: APB register file for the multi-channel SG DMA engine.
// Global regs at 0x000..0x008, one 16-byte block per channel from 0x100.
// Each channel keeps its pointer, an IDLE/BUSY state and sticky W1C flags.

// Per-channel slice: pointer register, IDLE/BUSY FSM, start pulse, flags.
module sgdmac_mch_chan (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmd_start,
  input  logic        i_ptr_we,
  input  logic [31:0] i_wdata,
  input  logic        i_done,
  input  logic [1:0]  i_w1c,
  output logic [31:0] o_ptr,
  output logic        o_start,
  output logic        o_busy,
  output logic [1:0]  o_flags
);
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_start, w_start_nxt;
  logic        w_set_done, w_set_err;
  logic [31:0] r_ptr;
  logic [1:0]  r_flags;

  // Next state: start only launches from IDLE; done only counts while BUSY.
  always_comb begin
    w_state_nxt = r_state;
    w_start_nxt = 1'b0;
    w_set_done  = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_start) begin
          w_state_nxt = S_BUSY;
          w_start_nxt = 1'b1;
        end
      end
      S_BUSY: begin
        if (i_cmd_start) w_set_err = 1'b1;
        if (i_done) begin
          w_state_nxt = S_IDLE;
          w_set_done  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, start pulse and flags; a flag set beats a same-cycle W1C clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      r_flags <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_start    <= w_start_nxt;
      r_flags[0] <= (r_flags[0] & ~i_w1c[0]) | w_set_done;
      r_flags[1] <= (r_flags[1] & ~i_w1c[1]) | w_set_err;
    end
  end

  // Pointer register; the top blocks writes while the channel is busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_ptr <= '0;
    else if (i_ptr_we) r_ptr <= i_wdata;
  end

  assign o_ptr   = r_ptr;
  assign o_start = r_start;
  assign o_busy  = (r_state == S_BUSY);
  assign o_flags = r_flags;
endmodule

// Top: APB decode, error response, read mux, IRQ enable and IRQ register.
module sgdmac_mch_cfg #(
  parameter int          N_CH    = 4,
  parameter logic [31:0] VERSION = 32'h0002_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic [11:0]       paddr_i,
  input  logic              pwrite_i,
  input  logic [31:0]       pwdata_i,
  output logic              pready_o,
  output logic [31:0]       prdata_o,
  output logic              pslverr_o,
  output logic [N_CH*32-1:0] start_pointer_o,
  output logic [N_CH-1:0]   start_o,
  output logic [N_CH-1:0]   busy_o,
  input  logic [N_CH-1:0]   done_i,
  output logic              irq_o
);
  logic                   w_access, w_glob_hit, w_chan_hit, w_ch_ok, w_ro;
  logic                   w_err, w_wr, w_busy_sel;
  logic [3:0]             w_ch;
  logic [1:0]             w_reg, w_flags_sel;
  logic [31:0]            w_ptr_sel, w_rdata;
  logic [N_CH-1:0]        r_irq_en, w_irq_stat, w_busy, w_start, w_done_flag;
  logic [N_CH-1:0][31:0]  w_ptr;
  logic [N_CH-1:0][1:0]   w_flags;
  logic                   r_irq;

  // Address decode: bits[1:0] are ignored, [3:2] pick the register.
  assign w_access   = psel_i & penable_i;
  assign w_ch       = paddr_i[7:4];
  assign w_reg      = paddr_i[3:2];
  assign w_ch_ok    = ({1'b0, w_ch} < 5'(N_CH));
  assign w_glob_hit = (paddr_i[11:4] == 8'h00) & (w_reg != 2'd3);
  assign w_chan_hit = (paddr_i[11:8] == 4'h1) & w_ch_ok;
  assign w_ro       = (w_glob_hit & (w_reg != 2'd1)) | (w_chan_hit & (w_reg == 2'd2));

  // Gather the addressed channel's state for error checks and reads.
  always_comb begin
    w_busy_sel  = 1'b0;
    w_ptr_sel   = '0;
    w_flags_sel = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (w_ch == 4'(c)) begin
        w_busy_sel  = w_busy[c];
        w_ptr_sel   = w_ptr[c];
        w_flags_sel = w_flags[c];
      end
    end
  end

  // Erroring accesses return zero and leave every register untouched.
  assign w_err = w_access & (~(w_glob_hit | w_chan_hit)
                 | (pwrite_i & w_ro)
                 | (pwrite_i & w_chan_hit & (w_reg == 2'd0) & w_busy_sel));
  assign w_wr  = w_access & pwrite_i & ~w_err;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      logic w_sel;
      assign w_sel = w_chan_hit & (w_ch == 4'(g));
      sgdmac_mch_chan u_chan (
        .clk         (clk),
        .rst         (rst),
        .i_cmd_start (w_wr & w_sel & (w_reg == 2'd1) & pwdata_i[0]),
        .i_ptr_we    (w_wr & w_sel & (w_reg == 2'd0)),
        .i_wdata     (pwdata_i),
        .i_done      (done_i[g]),
        .i_w1c       ((w_wr & w_sel & (w_reg == 2'd3)) ? pwdata_i[1:0] : 2'b00),
        .o_ptr       (w_ptr[g]),
        .o_start     (w_start[g]),
        .o_busy      (w_busy[g]),
        .o_flags     (w_flags[g])
      );
      assign w_done_flag[g] = w_flags[g][0];
    end
  endgenerate

  assign w_irq_stat = w_done_flag & r_irq_en;

  // Read mux, driven only during a clean read access.
  always_comb begin
    w_rdata = '0;
    if (w_access && !w_err && !pwrite_i) begin
      if (w_glob_hit) begin
        case (w_reg)
          2'd0:    w_rdata = VERSION;
          2'd1:    w_rdata = 32'(r_irq_en);
          2'd2:    w_rdata = 32'(w_irq_stat);
          default: w_rdata = '0;
        endcase
      end else begin
        case (w_reg)
          2'd0:    w_rdata = w_ptr_sel;
          2'd2:    w_rdata = {31'b0, w_busy_sel};
          2'd3:    w_rdata = {30'b0, w_flags_sel};
          default: w_rdata = '0;
        endcase
      end
    end
  end

  // IRQ enable register and registered interrupt (one cycle behind flags).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_en <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && w_glob_hit && (w_reg == 2'd1)) r_irq_en <= pwdata_i[N_CH-1:0];
      r_irq <= |w_irq_stat;
    end
  end

  assign pready_o        = 1'b1;
  assign prdata_o        = w_rdata;
  assign pslverr_o       = w_err;
  assign start_pointer_o = w_ptr;
  assign start_o         = w_start;
  assign busy_o          = w_busy;
  assign irq_o           = r_irq;
endmodule

// File: tb/tb_sgdmac_mch_cfg.sv
// Bench for sgdmac_mch_cfg: directed scenarios plus random APB traffic
// against a register-level reference model.
module tb_sgdmac_mch_cfg;
  localparam int          N   = 4;
  localparam logic [31:0] VER = 32'h0002_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              psel, penable, pwrite;
  logic [11:0]       paddr;
  logic [31:0]       pwdata;
  logic              pready, pslverr, irq;
  logic [31:0]       prdata;
  logic [N*32-1:0]   sp;
  logic [N-1:0]      start, busy, done;

  sgdmac_mch_cfg #(.N_CH(N), .VERSION(VER)) dut (
    .clk(clk), .rst(rst), .psel_i(psel), .penable_i(penable), .paddr_i(paddr),
    .pwrite_i(pwrite), .pwdata_i(pwdata), .pready_o(pready), .prdata_o(prdata),
    .pslverr_o(pslverr), .start_pointer_o(sp), .start_o(start), .busy_o(busy),
    .done_i(done), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural register contents.
  logic [31:0]  m_ptr [N];
  bit           m_busy [N];
  bit           m_dn [N];
  bit           m_se [N];
  bit [N-1:0]   m_irq_en, m_start;
  bit           m_irq;
  logic [31:0]  obs_prd;
  logic         obs_err;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < N; c++) begin
      m_ptr[c] = '0; m_busy[c] = 0; m_dn[c] = 0; m_se[c] = 0;
    end
    m_irq_en = '0; m_start = '0; m_irq = 0;
  endtask

  function automatic bit [N-1:0] m_stat();
    bit [N-1:0] s;
    for (int c = 0; c < N; c++) s[c] = m_dn[c] & m_irq_en[c];
    return s;
  endfunction

  function automatic void dec(input logic [11:0] ad, output int a, output int ch,
                              output int r, output bit mapped, output bit ro);
    a = int'(ad) & 'hFFC; ch = -1; r = 0; mapped = 0; ro = 0;
    if (a < 'h100) begin
      mapped = (a <= 8);
      ro     = (a != 4);
    end else if (a < 'h100 + 16 * N) begin
      ch = (a - 'h100) / 16;
      r  = (a % 16) / 4;
      mapped = 1;
      ro = (r == 2);
    end
  endfunction

  // One clock: check combinational APB outputs, advance the model, check registered outputs.
  task automatic step();
    int a, ch, r;
    bit mp, ro, acc, e, wok, nirq, sreq, dn;
    logic [31:0] rd;
    logic [N*32-1:0] esp;
    logic [N-1:0] ebusy;
    @(negedge clk);
    dec(paddr, a, ch, r, mp, ro);
    acc = psel && penable;
    e = acc && (!mp || (pwrite && ro) || (pwrite && ch >= 0 && r == 0 && m_busy[ch]));
    rd = '0;
    if (acc && !e && !pwrite) begin
      if (ch < 0) begin
        if (a == 0)      rd = VER;
        else if (a == 4) rd = 32'(m_irq_en);
        else             rd = 32'(m_stat());
      end else begin
        case (r)
          0:       rd = m_ptr[ch];
          2:       rd = 32'(m_busy[ch]);
          3:       rd = {30'b0, m_se[ch], m_dn[ch]};
          default: rd = '0;
        endcase
      end
    end
    chk("pready", pready, 1'b1);
    chk("pslverr", pslverr, e);
    if (!acc || !pwrite) chk("prdata", prdata, rd);
    obs_prd = prdata;
    obs_err = pslverr;
    wok  = acc && pwrite && !e;
    nirq = (m_stat() != 0);
    for (int c = 0; c < N; c++) begin
      sreq = wok && ch == c && r == 1 && pwdata[0];
      dn   = done[c] && m_busy[c];
      m_start[c] = sreq && !m_busy[c];
      if (wok && ch == c && r == 3) begin
        if (pwdata[0]) m_dn[c] = 0;
        if (pwdata[1]) m_se[c] = 0;
      end
      if (dn) m_dn[c] = 1;
      if (sreq && m_busy[c]) m_se[c] = 1;
      if (wok && ch == c && r == 0) m_ptr[c] = pwdata;
      m_busy[c] = m_busy[c] ? !dn : sreq;
    end
    if (wok && ch < 0 && a == 4) m_irq_en = pwdata[N-1:0];
    m_irq = nirq;
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      ebusy[c] = m_busy[c];
      esp[c*32 +: 32] = m_ptr[c];
    end
    chk("start_o", start, m_start);
    chk("busy_o", busy, ebusy);
    chk("start_pointer_o", sp, esp);
    chk("irq_o", irq, m_irq);
  endtask

  task automatic cyc(input bit s, input bit en, input bit wr, input logic [11:0] ad,
                     input logic [31:0] d, input logic [N-1:0] dn);
    psel = s; penable = en; pwrite = wr; paddr = ad; pwdata = d; done = dn;
    step();
  endtask

  task automatic apb(input bit wr, input logic [11:0] ad, input logic [31:0] d,
                     input logic [N-1:0] dn_setup, input logic [N-1:0] dn_acc);
    cyc(1, 0, wr, ad, d, dn_setup);
    cyc(1, 1, wr, ad, d, dn_acc);
  endtask

  task automatic idle(input logic [N-1:0] dn);
    cyc(0, 0, 0, 12'h0, 32'h0, dn);
  endtask

  logic [11:0] ra;
  logic [31:0] rdat;
  logic [N-1:0] rd1, rd2;

  initial begin
    rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; done = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, '0);
    chk("rst_start", start, '0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_ptr", sp, '0);
    rst = 0;
    idle('0);

    // Reset values through the bus.
    apb(0, 12'h000, 0, 0, 0);  chk("version", obs_prd, VER);
    apb(0, 12'h108, 0, 0, 0);  chk("status0", obs_prd, 32'h0);
    chk("pready_const", pready, 1'b1);

    // Pointer + start on channel 1.
    apb(1, 12'h110, 32'h8000_1000, 0, 0);
    apb(1, 12'h114, 32'h1, 0, 0);
    chk("start_pulse", start, 4'b0010);
    chk("busy1", busy[1], 1'b1);
    chk("ptr1_out", sp[63:32], 32'h8000_1000);
    idle('0);
    chk("start_one_cycle", start, 4'b0000);

    // Start while busy and pointer write while busy.
    apb(1, 12'h114, 32'h1, 0, 0);
    chk("no_restart", start, 4'b0000);
    apb(0, 12'h11C, 0, 0, 0);  chk("flags1_err", obs_prd, 32'h2);
    apb(1, 12'h110, 32'h1234_5678, 0, 0);
    chk("ptr_busy_err", obs_err, 1'b1);
    apb(0, 12'h110, 0, 0, 0);  chk("ptr1_kept", obs_prd, 32'h8000_1000);

    // Done, interrupt, W1C.
    apb(1, 12'h004, 32'h2, 0, 0);
    idle(4'b0010);
    chk("busy1_clr", busy[1], 1'b0);
    idle('0);
    chk("irq_set", irq, 1'b1);
    apb(0, 12'h11C, 0, 0, 0);  chk("flags1_done", obs_prd, 32'h3);
    apb(0, 12'h008, 0, 0, 0);  chk("irq_stat", obs_prd, 32'h2);
    apb(1, 12'h11C, 32'h1, 0, 0);
    idle('0);
    chk("irq_clr", irq, 1'b0);

    // Set beats W1C in the same cycle.
    apb(1, 12'h124, 32'h1, 0, 0);
    apb(1, 12'h12C, 32'h1, 0, 4'b0100);
    apb(0, 12'h12C, 0, 0, 0);  chk("set_wins", obs_prd[0], 1'b1);

    // Unmapped channel and RO write.
    apb(0, 12'h140, 0, 0, 0);
    chk("unmapped_err", obs_err, 1'b1);
    chk("unmapped_data", obs_prd, 32'h0);
    apb(1, 12'h000, 32'hFFFF_FFFF, 0, 0);
    chk("ro_err", obs_err, 1'b1);
    apb(0, 12'h004, 0, 0, 0);  chk("irq_en_kept", obs_prd, 32'h2);

    // Reset mid-transfer; a late done is ignored.
    apb(1, 12'h104, 32'h1, 0, 0);
    chk("busy0", busy[0], 1'b1);
    psel = 0; penable = 0; pwrite = 0;
    rst = 1;
    #1;
    chk("async_rst_busy", busy, '0);
    m_reset();
    @(posedge clk);
    #1;
    rst = 0;
    idle(4'b0001);
    apb(0, 12'h10C, 0, 0, 0);  chk("late_done_ignored", obs_prd, 32'h0);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 9))
        0:       ra = 12'($urandom_range(0, 3) * 4);
        8:       ra = 12'($urandom);
        9:       ra = 12'h200 | 12'($urandom_range(0, 255));
        default: ra = 12'h100 + 12'($urandom_range(0, N) * 16)
                      + 12'($urandom_range(0, 3) * 4) + 12'($urandom_range(0, 3));
      endcase
      rdat = $urandom;
      if ($urandom_range(0, 3) != 0) rdat[31:2] = '0;
      rd1 = N'($urandom & $urandom & $urandom);
      rd2 = N'($urandom & $urandom & $urandom);
      apb($urandom_range(0, 1), ra, rdat, rd1, rd2);
      if ($urandom_range(0, 4) == 0) idle(N'($urandom & $urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
